// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from a peripheral request/response port to an APB3 master.
// Optional ACCESS-phase timeout is enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req,
    input  logic [31:0]               add,
    input  logic                      wen,
    input  logic [31:0]               wdata,
    input  logic [ID_WIDTH-1:0]       id,
    output logic                      gnt,
    output logic                      r_valid,
    output logic                      r_opc,
    output logic [ID_WIDTH-1:0]       r_id,
    output logic [31:0]               r_rdata,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [31:0]               r_rdata_q, r_rdata_d;
    logic                      r_opc_q, r_opc_d;
    logic [ID_WIDTH-1:0]       r_id_q, r_id_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Only the low address bits reach the APB side.
    if (APB_ADDR_WIDTH < 32) begin : g_unused_add
        logic unused_add_hi;
        assign unused_add_hi = ^add[31:APB_ADDR_WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        id_d      = id_q;
        r_rdata_d = r_rdata_q;
        r_opc_d   = r_opc_q;
        r_id_d    = r_id_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    paddr_d  = add[APB_ADDR_WIDTH-1:0];
                    pwdata_d = wdata;
                    pwrite_d = ~wen;
                    id_d     = id;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    r_rdata_d = pwrite_q ? 32'h0 : PRDATA;
                    r_opc_d   = PSLVERR;
                    r_id_d    = id_q;
                    state_d   = StResp;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (cnt_q == CntMax) begin
                    r_rdata_d = 32'hDEAD_BEEF;
                    r_opc_d   = 1'b1;
                    r_id_d    = id_q;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            id_q      <= '0;
            r_rdata_q <= '0;
            r_opc_q   <= 1'b0;
            r_id_q    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            id_q      <= id_d;
            r_rdata_q <= r_rdata_d;
            r_opc_q   <= r_opc_d;
            r_id_q    <= r_id_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = req && (state_q == StIdle) && !HRESET;
    assign PSEL    = (state_q == StSetup) || (state_q == StAccess);
    assign PENABLE = (state_q == StAccess);
    assign r_valid = (state_q == StResp);
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign r_rdata = r_rdata_q;
    assign r_opc   = r_opc_q;
    assign r_id    = r_id_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Initiator-side counterpart to the peripheral APB slave wrappers.
- Accepts single-beat transactions on a XBAR_PERIPH_BUS-style request/response port and issues them as APB3 master transfers (SETUP/ACCESS).
- Sits between a core-side peripheral interconnect port and an APB slave, for example a cache-control register block.
- Handles one outstanding transaction at a time; responses are returned with the reflected request ID.

Parameters:
APB_ADDR_WIDTH, 12, width of PADDR; PADDR = add[APB_ADDR_WIDTH-1:0].
ID_WIDTH, 2, width of the id/r_id reflection field.
TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with APB_MASTER_TIMEOUT_EN.

Ports:
HCLK  in  1  clock, all logic rising-edge.
HRESET  in  1  synchronous active-high reset.
req  in  1  transaction request.
add  in  32  byte address.
wen  in  1  1=read, 0=write.
wdata  in  32  write data.
id  in  ID_WIDTH  request ID, reflected on r_id.
gnt  out  1  request accepted this cycle.
r_valid  out  1  one-cycle response strobe.
r_opc  out  1  response status: 1=error.
r_id  out  ID_WIDTH  reflected ID.
r_rdata  out  32  read data; 0 for writes.
PADDR  out  APB_ADDR_WIDTH  APB address.
PWDATA  out  32  APB write data.
PWRITE  out  1  APB direction.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PRDATA  in  32  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (HRESET=1 at an edge):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, r_valid and r_opc = 0.
  - PADDR, PWDATA, r_rdata and r_id = 0.
  - gnt = 0 while HRESET is high.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - gnt = req (combinational, IDLE only).
  - On req, capture add, wen, wdata and id into registers; go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0.
  - PADDR, PWDATA and PWRITE = ~wen, all from the captured values.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, data and direction stay stable.
  - While PREADY=0, stay in ACCESS (unbounded wait unless the timeout feature is enabled).
  - On PREADY=1:
    - r_rdata <= read ? PRDATA : 0.
    - r_opc <= PSLVERR.
    - r_id <= captured id.
    - Go to RESP.
- RESP:
  - r_valid=1 for exactly one cycle; PSEL=0, PENABLE=0.
  - Go to IDLE.
- All APB and response outputs are registered (driven from state and capture registers); only gnt is combinational.
- Latency with zero wait states:
  - Accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, r_valid at cycle 3.
  - The next gnt comes at cycle 4 at the earliest.
  - Each PREADY wait state adds 1 cycle.
- Request-side rules:
  - req is ignored outside IDLE; the requester must hold req, add, wen, wdata and id until gnt.
  - A request deasserted before gnt is dropped without side effects.
- r_rdata, r_opc and r_id hold their values after r_valid until the next response.
- PADDR, PWDATA and PWRITE hold their last values when PSEL=0.
- Reset mid-transaction (SETUP/ACCESS/RESP):
  - PSEL/PENABLE drop at the reset edge.
  - No r_valid is issued; the in-flight transaction is lost.
- PREADY and PSLVERR are ignored outside ACCESS.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES-1 with PREADY still 0, the transfer aborts: next state is RESP with r_opc=1, r_rdata=32'hDEADBEEF and PSEL/PENABLE deasserted.
  - PREADY=1 on the final counted cycle wins over the timeout (normal completion).
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write, zero wait: req, wen=0, add=32'h0000_0A04, wdata=32'h1234_5678, id=1 → gnt at cycle 0; PSEL=1/PENABLE=0 at cycle 1 with PADDR=12'hA04, PWRITE=1; PENABLE=1 at cycle 2; r_valid at cycle 3 with r_opc=0, r_id=1, r_rdata=0.
- Read, 3 wait states: wen=1, add=12'h010, PREADY low for 3 ACCESS cycles then high with PRDATA=32'hCAFE_0001 → r_valid at cycle 6, r_rdata=32'hCAFE_0001, PWRITE=0 throughout.
- Slave error: read completing with PREADY=1, PSLVERR=1 → r_valid with r_opc=1; next transaction has r_opc=0.
- Back-to-back: req held high continuously → gnt at cycles 0 and 4; no gnt in cycles 1-3; IDs 0 then 2 returned in order.
- Reset in ACCESS: HRESET pulsed while PREADY=0 → PSEL=PENABLE=0 after the edge; no r_valid ever issued; next req granted in IDLE.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8): PREADY stuck at 0 → abort after 8 ACCESS cycles; r_valid with r_opc=1, r_rdata=32'hDEADBEEF; no abort if PREADY rises on the 8th cycle.
